mcp3008_responder: RTL and testbench

Synthesizable SPI responder that emulates the MCP3008 8-channel 10-bit ADC at the device end of the SPI link. It decodes the start bit and channel command from the SPI controller, latches a parallel sample for the requested channel, and shifts it back MSB-first with the device's null bit and LSB-first tail. Its uses:
- bench and loopback partner for the existing SPI ADC controllers;
- on-board stand-in that feeds synthetic audio or pot codes into the filter path without the external chip.

---
 rtl/audio_pkg.sv | 16 +
 rtl/sync_edge.sv | 38 +++
 rtl/mcp3008_responder.sv | 196 +++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio/ADC front-end blocks.
package audio_pkg;

    localparam int unsigned N_DEFAULT = 10;
    localparam int unsigned CMD_BITS  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        NULL,
        MSB,
        LSB,
        TAIL
    } spi_resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; level output is
// delayed one cycle so it stays aligned with the edge pulses.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/mcp3008_responder.sv
// SPI device-side emulation of an MCP3008 ADC: decodes start/command bits,
// latches the selected channel and returns null + MSB-first + LSB-first tail.
module mcp3008_responder
    import audio_pkg::*;
#(
    parameter int unsigned N           = N_DEFAULT,
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    input  logic [CHANNELS-1:0][N-1:0]   ch_data,
    output logic [2:0]                   ch_sel,
    output logic                         sgl_diff,
    output logic                         conv_strobe,
    output logic                         busy
);

    localparam int unsigned        CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]   LAST     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]   CMD_LAST = CNT_W'(CMD_BITS - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_s, cs_rise, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (sclk),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (cs_n),
        .level_o (cs_s),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (mosi),
        .level_o (mosi_s),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    spi_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             miso_q, miso_d;
    logic             oe_q, oe_d;
    logic [2:0]       ch_sel_q, ch_sel_d;
    logic             sgl_q, sgl_d;
    logic             strobe_q, strobe_d;

    logic [3:0]       cmd_word;
    logic [N-1:0]     sel_data;

    // Full command once the current rise's bit is appended: {SGL/DIFF, D2, D1, D0}.
    assign cmd_word = {cmd_q, mosi_s};

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(cmd_word[2:0]) == i) begin
                sel_data = ch_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            cmd_q    <= '0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            ch_sel_q <= '0;
            sgl_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            cmd_q    <= cmd_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            ch_sel_q <= ch_sel_d;
            sgl_q    <= sgl_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        cmd_d    = cmd_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        ch_sel_d = ch_sel_q;
        sgl_d    = sgl_q;
        strobe_d = 1'b0;

        // Chip-select release wins over any SCLK edge in the same cycle.
        if (cs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d   = 1'b0;
                    miso_d = 1'b0;
                    if (sclk_rise && !cs_s && mosi_s) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = cmd_word[2:0];
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CMD_LAST) begin
                            sgl_d    = cmd_word[3];
                            ch_sel_d = cmd_word[2:0];
                            shreg_d  = sel_data;
                            strobe_d = 1'b1;
                            state_d  = NULL;
                        end
                    end
                end
                NULL: begin
                    if (sclk_fall) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        cnt_d   = LAST;
                        state_d = MSB;
                    end
                end
                MSB: begin
                    if (sclk_fall) begin
                        miso_d = shreg_q[cnt_q];
                        if (cnt_q == '0) begin
                            cnt_d   = CNT_W'(1);
                            state_d = LSB;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                LSB: begin
                    if (sclk_fall) begin
                        miso_d = shreg_q[cnt_q];
                        if (cnt_q == LAST) begin
                            state_d = TAIL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (sclk_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = oe_q;
    assign ch_sel      = ch_sel_q;
    assign sgl_diff    = sgl_q;
    assign conv_strobe = strobe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mcp3008_responder.sv
// Self-checking bench: acts as SPI controller and compares the returned
// bitstream against the MCP3008 framing rules.
module tb_mcp3008_responder;

    localparam int N    = 10;
    localparam int CH   = 6;
    localparam int HALF = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sclk = 1'b0;
    logic                   cs_n = 1'b1;
    logic                   mosi = 1'b0;
    logic                   miso, miso_oe, sgl_diff, conv_strobe, busy;
    logic [2:0]             ch_sel;
    logic [CH-1:0][N-1:0]   ch_data = '0;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    mcp3008_responder #(
        .N           (N),
        .CHANNELS    (CH),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .ch_data     (ch_data),
        .ch_sel      (ch_sel),
        .sgl_diff    (sgl_diff),
        .conv_strobe (conv_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (conv_strobe === 1'b1) strobes++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int           lead;
        bit           cpol;
        logic [2:0]   ch;
        bit           sgl;
        int           nrise;
        logic [N-1:0] data;
        logic [2:0]   exp_ch;
        bit           exp_sgl;
        int           exp_str;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    // Value a controller sees at its k-th rising SCLK: null bit, N bits MSB-first,
    // then bits 1..N-1 LSB-first, then zeros.
    function automatic logic exp_bit(input int k, input int lead, input logic [N-1:0] d);
        int j;
        j = k - (lead + 5);
        if (j <= 0) return 1'b0;
        if (j <= N) return d[N - j];
        if (j <= 2 * N - 1) return d[j - N];
        return 1'b0;
    endfunction

    task automatic frame(input string tag, input int lead, input bit cpol, input logic [2:0] ch,
                         input bit sgl, input int nrise, input bit scramble, input int reset_at,
                         input logic [2:0] exp_ch, input bit exp_sgl, input int exp_str);
        logic [63:0]  got_d, exp_d, got_oe, exp_oe;
        logic [N-1:0] d;
        logic [4:0]   cmd;
        int           s0;
        got_d = '0; exp_d = '0; got_oe = '0; exp_oe = '0;
        d = '0;
        if (int'(ch) < CH) d = ch_data[ch];
        cmd = {1'b1, sgl, ch};
        s0 = strobes;
        sclk = cpol;
        half();
        cs_n = 1'b0;
        half();
        for (int k = 0; k < nrise; k++) begin
            sclk = 1'b0;
            if (k < lead) mosi = 1'b0;
            else if (k < lead + 5) mosi = cmd[4 - (k - lead)];
            else mosi = 1'($urandom);
            if (scramble && k == lead + 5) begin
                for (int i = 0; i < CH; i++) ch_data[i] = N'($urandom);
            end
            half();
            got_d[k]  = miso;
            got_oe[k] = miso_oe;
            exp_d[k]  = exp_bit(k, lead, d);
            exp_oe[k] = (k >= lead + 5);
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check($sformatf("%s reset_outputs", tag),
                      64'({miso, miso_oe, ch_sel, sgl_diff, conv_strobe, busy}), 64'd0);
                break;
            end
            sclk = 1'b1;
            half();
        end
        if (!cpol) sclk = 1'b0;
        half();
        cs_n = 1'b1;
        sclk = cpol;
        repeat (4) @(negedge clk);
        check($sformatf("%s idle_after_cs", tag), 64'({miso_oe, busy}), 64'd0);
        check($sformatf("%s miso_stream", tag), got_d, exp_d);
        check($sformatf("%s miso_oe", tag), got_oe, exp_oe);
        check($sformatf("%s ch_sel", tag), 64'(ch_sel), 64'(exp_ch));
        check($sformatf("%s sgl_diff", tag), 64'(sgl_diff), 64'(exp_sgl));
        check($sformatf("%s strobes", tag), 64'(strobes - s0), 64'(exp_str));
        half();
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 3'd3, 1'b1, 16, 10'h2A5, 3'd3, 1'b1, 1};
        tbl[1] = '{3, 1'b0, 3'd0, 1'b1, 19, 10'h3FF, 3'd0, 1'b1, 1};
        tbl[2] = '{0, 1'b0, 3'd1, 1'b1, 36, 10'h001, 3'd1, 1'b1, 1};
        tbl[3] = '{0, 1'b0, 3'd6, 1'b1, 16, 10'h155, 3'd6, 1'b1, 1};
        tbl[4] = '{1, 1'b1, 3'd5, 1'b0, 27, 10'h1C3, 3'd5, 1'b0, 1};
        tbl[5] = '{2, 1'b1, 3'd7, 1'b0, 20, 10'h2AA, 3'd7, 1'b0, 1};

        for (int i = 0; i < CH; i++) ch_data[i] = N'($urandom);
        repeat (3) @(negedge clk);
        check("reset_held", 64'({miso, miso_oe, ch_sel, sgl_diff, conv_strobe, busy}), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("after_reset", 64'({miso, miso_oe, ch_sel, sgl_diff, conv_strobe, busy}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if (int'(tbl[i].ch) < CH) ch_data[tbl[i].ch] = tbl[i].data;
            frame($sformatf("vec%0d", i), tbl[i].lead, tbl[i].cpol, tbl[i].ch, tbl[i].sgl,
                  tbl[i].nrise, 1'b0, -1, tbl[i].exp_ch, tbl[i].exp_sgl, tbl[i].exp_str);
        end

        // Abort after six data bits, then abort inside the command phase.
        ch_data[3] = 10'h2A5;
        frame("abort_data", 0, 1'b0, 3'd3, 1'b1, 12, 1'b0, -1, 3'd3, 1'b1, 1);
        frame("abort_cmd", 0, 1'b0, 3'd2, 1'b0, 3, 1'b0, -1, 3'd3, 1'b1, 0);
        ch_data[2] = 10'h0F0;
        frame("after_abort", 0, 1'b0, 3'd2, 1'b0, 16, 1'b0, -1, 3'd2, 1'b0, 1);

        // Reset pulse during MSB phase, then a clean frame.
        ch_data[4] = 10'h36C;
        frame("reset_mid", 0, 1'b0, 3'd4, 1'b1, 16, 1'b0, 9, 3'd0, 1'b0, 1);
        frame("after_reset_frame", 0, 1'b0, 3'd4, 1'b1, 16, 1'b0, -1, 3'd4, 1'b1, 1);

        for (int r = 0; r < 20; r++) begin
            int         lead;
            bit         cpol, sgl;
            logic [2:0] ch;
            int         nrise;
            lead  = int'($urandom_range(0, 3));
            cpol  = 1'($urandom);
            sgl   = 1'($urandom);
            ch    = 3'($urandom_range(0, 7));
            nrise = int'($urandom_range(lead + 5, lead + 33));
            for (int i = 0; i < CH; i++) ch_data[i] = N'($urandom);
            frame($sformatf("rand%0d", r), lead, cpol, ch, sgl, nrise, 1'b1, -1, ch, sgl, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
